// File: rtl/sop.sv
// sop: registered five-input sum-of-products evaluator.
// Minimized and canonical forms are cross-checked into a sticky flag.
module sop #(
  parameter bit INPUT_REG = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic e,
  output logic out,
  output logic mismatch
);

  logic [4:0] vin;
  logic [4:0] v;

  assign vin = {a, b, c, d, e};

  generate
    if (INPUT_REG) begin : g_ireg
      logic [4:0] vq;
      // optional input stage; clears to minterm 0 on reset
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vq <= 5'b0;
        else        vq <= vin;
      end
      assign v = vq;
    end else begin : g_noreg
      assign v = vin;
    end
  endgenerate

  logic va, vb, vc, vd, ve;
  logic na, nb, nc, nd, ne;

  assign va = v[4];
  assign vb = v[3];
  assign vc = v[2];
  assign vd = v[1];
  assign ve = v[0];
  assign na = ~va;
  assign nb = ~vb;
  assign nc = ~vc;
  assign nd = ~vd;
  assign ne = ~ve;

  logic p1, p2, p3, p4;
  logic minf;

  assign p1 = na & nb & nc;
  assign p2 = vb & vd & ne;
  assign p3 = va & vc & ve;
  assign p4 = nb & vc & nd;
  assign minf = p1 | p2 | p3 | p4;

  logic [14:0] mt;
  logic canon;

  assign mt[0]  = na & nb & nc & nd & ne;
  assign mt[1]  = na & nb & nc & nd & ve;
  assign mt[2]  = na & nb & nc & vd & ne;
  assign mt[3]  = na & nb & nc & vd & ve;
  assign mt[4]  = na & nb & vc & nd & ne;
  assign mt[5]  = na & nb & vc & nd & ve;
  assign mt[6]  = na & vb & nc & vd & ne;
  assign mt[7]  = na & vb & vc & vd & ne;
  assign mt[8]  = va & nb & vc & nd & ne;
  assign mt[9]  = va & nb & vc & nd & ve;
  assign mt[10] = va & nb & vc & vd & ve;
  assign mt[11] = va & vb & nc & vd & ne;
  assign mt[12] = va & vb & vc & nd & ve;
  assign mt[13] = va & vb & vc & vd & ne;
  assign mt[14] = va & vb & vc & vd & ve;
  assign canon  = |mt;

  // result register plus sticky disagreement flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out      <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      out      <= minf;
      mismatch <= mismatch | (minf ^ canon);
    end
  end

endmodule

// File: tb/tb_sop.sv
// tb_sop: directed bench for sop, both input-register variants.
// Expected outputs come from an ON-set mask and a queue scoreboard.
module tb_sop;

  logic clk;
  logic rst_n;
  logic a, b, c, d, e;
  logic out0, mis0;
  logic out2, mis2;

  sop #(.INPUT_REG(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .out(out0), .mismatch(mis0)
  );

  sop #(.INPUT_REG(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .out(out2), .mismatch(mis2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] onset;
  logic q0 [$];
  logic [4:0] ireg;
  logic em0, em2;
  int checks;
  int errors;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] m);
    {a, b, c, d, e} = m;
    q0.push_back(onset[m]);
  endtask

  task automatic after_edge(input logic [4:0] m);
    logic exp0;
    logic exp2;
    if (q0.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty m=%0d observed=empty expected=entry", m);
      exp0 = 1'bx;
    end else begin
      exp0 = q0.pop_front();
    end
    exp2 = onset[ireg];
    ireg = m;
    chk($sformatf("out0_m%0d", m), out0, exp0);
    chk($sformatf("out2_m%0d", m), out2, exp2);
    chk($sformatf("mis0_m%0d", m), mis0, em0);
    chk($sformatf("mis2_m%0d", m), mis2, em2);
  endtask

  task automatic step(input logic [4:0] m);
    drive(m);
    @(posedge clk);
    #1;
    after_edge(m);
    @(negedge clk);
  endtask

  initial begin
    onset  = 32'hE4B0_443F;
    checks = 0;
    errors = 0;
    em0    = 1'b0;
    em2    = 1'b0;
    ireg   = 5'd0;
    rst_n  = 1'b0;
    {a, b, c, d, e} = 5'b0;

    #2;
    chk("rst_out0", out0, 1'b0);
    chk("rst_mis0", mis0, 1'b0);
    chk("rst_out2", out2, 1'b0);
    chk("rst_mis2", mis2, 1'b0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) step(5'(i));

    step(5'd21);
    step(5'd31);
    step(5'd6);
    step(5'd10);
    step(5'd11);

    step(5'd21);
    rst_n = 1'b0;
    #1;
    chk("midrst_out0", out0, 1'b0);
    chk("midrst_out2", out2, 1'b0);
    ireg = 5'd0;
    #1;
    rst_n = 1'b1;
    step(5'd3);
    step(5'd22);
    step(5'd23);

    drive(5'd14);
    force dut.canon = 1'b0;
    @(posedge clk);
    #1;
    release dut.canon;
    em0 = 1'b1;
    after_edge(5'd14);
    @(negedge clk);
    step(5'd5);
    step(5'd22);
    step(5'd0);

    rst_n = 1'b0;
    #1;
    em0 = 1'b0;
    ireg = 5'd0;
    chk("clr_mis0", mis0, 1'b0);
    chk("clr_out0", out0, 1'b0);
    #1;
    rst_n = 1'b1;
    step(5'd30);
    step(5'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sop.md
# sop

Registered five-input sum-of-products evaluator implementing the fixed Boolean function F(a,b,c,d,e) = Σm(0,1,2,3,4,5,10,14,20,21,23,26,29,30,31). It computes F two ways: the minimized four-product form and the canonical 15-minterm form. It registers the result and raises a sticky self-check flag if the two forms ever disagree. It sits as a leaf logic block in the datapath, and the 5-bit exhaustive sweep is its reference stimulus.

## Interface
- INPUT_REG, default 0: when 1, inputs pass through an extra register stage before evaluation (latency 2); when 0, latency 1.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a  in  1  function input, MSB of minterm index (weight 16)
- b  in  1  function input (weight 8)
- c  in  1  function input (weight 4)
- d  in  1  function input (weight 2)
- e  in  1  function input, LSB (weight 1)
- out  out  1  registered F(a,b,c,d,e), minimized form
- mismatch  out  1  sticky flag; set when minimized and canonical forms differ

## Operation
- Minterm index m = {a,b,c,d,e}, with a as the MSB.
- Minimized form, four products ORed:
  - P1 = a'·b'·c' covers m 0–3.
  - P2 = b·d·e' covers m 10, 14, 26, 30.
  - P3 = a·c·e covers m 21, 23, 29, 31.
  - P4 = b'·c·d' covers m 4, 5, 20, 21.
- Canonical form: OR of 15 five-literal minterm products over exactly the ON-set {0,1,2,3,4,5,10,14,20,21,23,26,29,30,31}. F is 0 for all other 17 indices.
- Both forms are pure combinational AND/OR/NOT networks on the evaluated input vector. No lookup table and no behavioural case statement for the ON-set.
- Each rising edge, out ← minimized-form result.
- Each rising edge, mismatch ← mismatch | (min ≠ canon).
- The mismatch flag clears only on reset.
- Inputs that are X/Z are not qualified; the block propagates whatever the gates produce.

## Timing
- Reset (rst_n low) takes effect asynchronously:
  - out = 0 and mismatch = 0 immediately.
  - Any input register (INPUT_REG=1) clears to 5'b0.
  - This applies regardless of clock, including mid-sweep.
- Reset is released synchronously to the first rising edge after rst_n goes high. Reset values hold until that edge.
- INPUT_REG=0: out reflects inputs sampled at edge k, visible after edge k. The inputs must be stable in the setup window before edge k.
- INPUT_REG=1: the inputs sampled at edge k appear on out after edge k+1. Consequently, after reset release the first edge makes out = F(0) = 1, because the input register holds 0.
- Input changes between edges never glitch out; out changes only at rising edges or on asynchronous reset.
- Back-to-back input changes every cycle are supported at full throughput.

## Test plan
- Reset value: assert rst_n=0 with a..e=0 → out=0 and mismatch=0 immediately. Release reset; after one edge (INPUT_REG=0) → out=1, since F(0)=1.
- Exhaustive sweep: apply m = 0..31 in ascending order, one per clock. After each edge, out equals the ON-set membership of the previous cycle's m. For example:
  - m=3 → 1, m=6 → 0, m=10 → 1, m=11 → 0.
  - m=21 → 1, m=22 → 0, m=31 → 1.
  - mismatch remains 0 throughout.
- Overlap term: m=21 (a=1,b=0,c=1,d=0,e=1), covered by both P3 and P4 → out=1, mismatch=0.
- Latency with INPUT_REG=1: apply m=31 at edge k, then m=6 at edge k+1 → out=1 after edge k+1 and out=0 after edge k+2.
- Mid-operation reset: during the sweep with out=1, pulse rst_n low between edges → out drops to 0 without a clock edge. After release, the next evaluated m sets out accordingly.
- Mismatch path: force one canonical minterm (e.g. m=14) low in simulation and apply m=14 → mismatch=1 after the edge. It stays 1 through later vectors and clears only on rst_n=0.
